// File: rtl/bus_pkg.sv
// Shared definitions for the MEM-stage device bus: address map, TCON bit
// positions and the target-select encoding used by the decoder.
package bus_pkg;

  localparam logic [31:0] PERIPH_BASE  = 32'h4000_0000;
  localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
  localparam logic [31:0] ADDR_LED     = 32'h4000_000C;
  localparam logic [31:0] ADDR_DIGITS  = 32'h4000_0010;
  localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0014;

  localparam int TCON_EN  = 0;
  localparam int TCON_IEN = 1;
  localparam int TCON_IRQ = 2;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_TIMER,
    SEL_LED,
    SEL_DIGITS,
    SEL_SYSTICK,
    SEL_NONE
  } sel_e;

  // Word offset of a peripheral register relative to PERIPH_BASE.
  function automatic logic [2:0] periphIndex(input logic [31:0] addr);
    return addr[4:2];
  endfunction

endpackage

// File: rtl/bus_timer.sv
// Timer block: reload value TH, counter TL, control/status TCON (whose irq
// status bit drives irq_o) and the free-running SYSTICK cycle counter.
// regIdx_i selects the register for both writes and the read mux:
// 0=TH, 1=TL, 2=TCON, 5=SYSTICK (SYSTICK is never written).
module bus_timer
  import bus_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        we_i,
  input  logic [2:0]  regIdx_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [31:0] systick_q, systick_d;

  // Next state: hardware tick/reload first, then a software write overrides it.
  always_comb begin
    th_d      = th_q;
    tl_d      = tl_q;
    tcon_d    = tcon_q;
    systick_d = systick_q + 32'd1;
    if (tcon_q[TCON_EN]) begin
      if (tl_q == 32'hFFFF_FFFF) begin
        tl_d = th_q;
        if (tcon_q[TCON_IEN]) tcon_d[TCON_IRQ] = 1'b1;
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end
    if (we_i) begin
      case (regIdx_i)
        3'd0:    th_d   = wdata_i;
        3'd1:    tl_d   = wdata_i;
        3'd2:    tcon_d = wdata_i[2:0];
        default: ;
      endcase
    end
  end

  // Register update; reset clears every timer register and SYSTICK.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      systick_q <= '0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      systick_q <= systick_d;
    end
  end

  // Combinational read mux over the timer registers.
  always_comb begin
    case (regIdx_i)
      3'd0:    rdata_o = th_q;
      3'd1:    rdata_o = tl_q;
      3'd2:    rdata_o = {29'd0, tcon_q};
      3'd5:    rdata_o = systick_q;
      default: rdata_o = '0;
    endcase
  end

  assign irq_o = tcon_q[TCON_IRQ];

endmodule

// File: rtl/device_bus.sv
// MEM-stage data bus: decodes each access to the data RAM, the timer block
// or the LED/DIGITS output registers and returns read data combinationally.
module device_bus
  import bus_pkg::*;
#(
  parameter int RAM_WORDS = 256,
  parameter int LED_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       MemBus_Address,
  input  logic [31:0]       MemBus_Write_Data,
  output logic [31:0]       Device_Read_Data,
  output logic [LED_W-1:0]  leds,
  output logic [11:0]       digits,
  output logic              irq
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]      ram_q [RAM_WORDS];
  logic [LED_W-1:0] leds_q;
  logic [11:0]      digits_q;
  logic [31:0]      wordAddr;
  logic [AW-1:0]    ramIdx;
  sel_e             sel;
  logic             timerWe;
  logic [31:0]      timerRdata;

  assign wordAddr = MemBus_Address & ~32'h3;
  assign ramIdx   = MemBus_Address[AW+1:2];

  // Address decode: low window is RAM, exact word matches are peripherals.
  always_comb begin
    sel = SEL_NONE;
    if (MemBus_Address[31:AW+2] == '0) begin
      sel = SEL_RAM;
    end else begin
      case (wordAddr)
        ADDR_TH, ADDR_TL, ADDR_TCON: sel = SEL_TIMER;
        ADDR_LED:                    sel = SEL_LED;
        ADDR_DIGITS:                 sel = SEL_DIGITS;
        ADDR_SYSTICK:                sel = SEL_SYSTICK;
        default:                     sel = SEL_NONE;
      endcase
    end
  end

  assign timerWe = MemWrite && (sel == SEL_TIMER);

  bus_timer u_timer (
    .clk_i    (clk),
    .reset_i  (reset),
    .we_i     (timerWe),
    .regIdx_i (periphIndex(MemBus_Address)),
    .wdata_i  (MemBus_Write_Data),
    .rdata_o  (timerRdata),
    .irq_o    (irq)
  );

  // Data RAM; the whole array clears in the reset cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RAM_WORDS; i++) ram_q[i] <= '0;
    end else if (MemWrite && (sel == SEL_RAM)) begin
      ram_q[ramIdx] <= MemBus_Write_Data;
    end
  end

  // LED and 7-segment output registers keep only their low bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      leds_q   <= '0;
      digits_q <= '0;
    end else if (MemWrite) begin
      if (sel == SEL_LED)    leds_q   <= MemBus_Write_Data[LED_W-1:0];
      if (sel == SEL_DIGITS) digits_q <= MemBus_Write_Data[11:0];
    end
  end

  // Read mux; idle or unmapped reads return zero.
  always_comb begin
    Device_Read_Data = '0;
    if (MemRead) begin
      case (sel)
        SEL_RAM:                Device_Read_Data = ram_q[ramIdx];
        SEL_TIMER, SEL_SYSTICK: Device_Read_Data = timerRdata;
        SEL_LED:                Device_Read_Data = 32'(leds_q);
        SEL_DIGITS:             Device_Read_Data = {20'd0, digits_q};
        default:                Device_Read_Data = '0;
      endcase
    end
  end

  assign leds   = leds_q;
  assign digits = digits_q;

endmodule
